vending_machine_multi: RTL

// - Parametrised successor vending FSM: N items with per-item prices, credit accumulator, multi-unit change.
// - Accepts 1- and 5-unit coins, vends one item per purchase, returns the remainder one unit per cycle.
// - Sits between coin/keypad front-end and dispenser/changer drivers.

---
 rtl/vm_pkg.sv | 12 +
 rtl/vm_credit_acc.sv | 45 ++++
 rtl/vending_machine_multi.sv | 85 ++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared states, coin values and price lookup for vending_machine_multi.
package vm_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    localparam int COIN1_VAL   = 1;
    localparam int COIN5_VAL   = 5;
    localparam int DISP_ITEM_W = 3;
    function automatic logic [31:0] price_of(input logic [63:0] list, input int idx, input int pw);
        logic [63:0] mask;
        mask = (64'd1 << pw) - 64'd1;
        return 32'((list >> (idx * pw)) & mask);
    endfunction
endpackage

// File: rtl/vm_credit_acc.sv
// vm_credit_acc: credit register with coin add, ceiling check, purchase debit and change decrement.
module vm_credit_acc import vm_pkg::*; #(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_p1,
    input  logic                i_p5,
    input  logic                i_coin_ok,
    input  logic                i_debit,
    input  logic [CREDIT_W-1:0] i_debit_amt,
    input  logic                i_dec,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [CREDIT_W-1:0] o_credit_nxt,
    output logic                o_coin_rej
);
    localparam int SUM_W = CREDIT_W + 3;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_coin_rej;
    logic [SUM_W-1:0]    w_sum;
    logic                w_coin;
    logic                w_add;
    // A cycle's coins are taken or refused together, so the sum includes both pulses.
    always_comb begin
        w_coin       = i_p1 | i_p5;
        w_sum        = SUM_W'(r_credit) + (i_p1 ? SUM_W'(COIN1_VAL) : '0) + (i_p5 ? SUM_W'(COIN5_VAL) : '0);
        w_add        = i_coin_ok & w_coin & (w_sum <= SUM_W'(MAX_CREDIT));
        o_credit_nxt = i_debit ? r_credit - i_debit_amt
                     : i_dec   ? r_credit - CREDIT_W'(1)
                     : w_add   ? w_sum[CREDIT_W-1:0]
                     : r_credit;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_credit   <= '0;
            r_coin_rej <= 1'b0;
        end else begin
            r_credit   <= o_credit_nxt;
            r_coin_rej <= w_coin & ~w_add;
        end
    end
    assign o_credit   = r_credit;
    assign o_coin_rej = r_coin_rej;
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending FSM with credit accumulator and unit-per-cycle change.
// Optional credit refund input enabled by defining VM_REFUND_EN.
module vending_machine_multi import vm_pkg::*; #(
    parameter int                           NUM_ITEMS  = 2,
    parameter int                           PRICE_W    = 4,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_LIST = {4'd3, 4'd2},
    parameter int                           CREDIT_W   = 4,
    parameter int                           MAX_CREDIT = 15
) (
    input  logic                   Clk,
    input  logic                   nrst,
    input  logic                   p1,
    input  logic                   p5,
    input  logic [NUM_ITEMS-1:0]   item_sel,
`ifdef VM_REFUND_EN
    input  logic                   refund,
`endif
    output logic                   disp,
    output logic [DISP_ITEM_W-1:0] disp_item,
    output logic                   change,
    output logic                   coin_rej,
    output logic                   no_funds,
    output logic [CREDIT_W-1:0]    credit,
    output logic                   busy
);
    state_t                 r_state, w_state_nxt;
    logic [DISP_ITEM_W-1:0] w_sel_idx, r_disp_item;
    logic [CREDIT_W-1:0]    w_price, w_credit, w_credit_nxt;
    logic                   w_sel_any, w_idle_cr, w_funded, w_refund;
    logic                   r_disp, r_change, r_no_funds, r_busy;
`ifdef VM_REFUND_EN
    assign w_refund = (r_state == CREDIT) & refund & ~w_sel_any;
`else
    assign w_refund = 1'b0;
`endif
    // Scan from the top down so the lowest set request bit ends up selected.
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--)
            if (item_sel[i]) w_sel_idx = DISP_ITEM_W'(i);
        w_sel_any   = |item_sel;
        w_idle_cr   = (r_state == IDLE) | (r_state == CREDIT);
        w_price     = CREDIT_W'(price_of(64'(PRICE_LIST), int'(w_sel_idx), PRICE_W));
        w_funded    = w_idle_cr & w_sel_any & (w_credit >= w_price);
        w_state_nxt = w_idle_cr         ? (w_funded ? VEND : w_refund ? CHANGE : (w_credit_nxt != '0) ? CREDIT : IDLE)
                    : r_state == VEND   ? ((w_credit != '0) ? CHANGE : IDLE)
                    : (w_credit > CREDIT_W'(1)) ? CHANGE : IDLE;
    end
    vm_credit_acc #(.CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT)) u_acc (
        .i_clk        (Clk),
        .i_rst        (nrst),
        .i_p1         (p1),
        .i_p5         (p5),
        .i_coin_ok    (w_idle_cr & ~w_funded & ~w_refund),
        .i_debit      (w_funded),
        .i_debit_amt  (w_price),
        .i_dec        (r_state == CHANGE),
        .o_credit     (w_credit),
        .o_credit_nxt (w_credit_nxt),
        .o_coin_rej   (coin_rej)
    );
    always_ff @(posedge Clk) begin
        if (nrst) begin
            r_state     <= IDLE;
            r_disp      <= 1'b0;
            r_disp_item <= '0;
            r_change    <= 1'b0;
            r_no_funds  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_disp      <= w_funded;
            r_disp_item <= w_funded ? w_sel_idx : '0;
            r_change    <= w_state_nxt == CHANGE;
            r_no_funds  <= w_idle_cr & w_sel_any & ~w_funded;
            r_busy      <= (w_state_nxt == VEND) | (w_state_nxt == CHANGE);
        end
    end
    assign disp      = r_disp;
    assign disp_item = r_disp_item;
    assign change    = r_change;
    assign no_funds  = r_no_funds;
    assign credit    = w_credit;
    assign busy      = r_busy;
endmodule
